// File: rtl/cell_redraw_seq_if.sv
// Painter-side handshake bundle between cell_redraw_seq (master) and the box painter (slave).
interface cell_redraw_seq_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 9
);
  // pnt_start is a one-cycle kick issued only while pnt_busy is low; pnt_x0/y0/color are
  // valid with the kick and held until the one-cycle pnt_done that retires it.
  logic               pnt_start;
  logic [X_W-1:0]     pnt_x0;
  logic [Y_W-1:0]     pnt_y0;
  logic [COLOR_W-1:0] pnt_color;
  logic               pnt_busy;
  logic               pnt_done;

  modport master (
    output pnt_start, pnt_x0, pnt_y0, pnt_color,
    input  pnt_busy, pnt_done
  );

  modport slave (
    input  pnt_start, pnt_x0, pnt_y0, pnt_color,
    output pnt_busy, pnt_done
  );
endinterface

// File: rtl/cell_redraw_seq.sv
// Erase/redraw sequencer for a CELLS-cell piece plus full-grid background clear,
// issuing one box paint per cell through the painter handshake.
module cell_redraw_seq #(
  parameter int                 COLS     = 10,
  parameter int                 ROWS     = 20,
  parameter int                 CELLS    = 4,
  parameter int                 COL_W    = 4,
  parameter int                 ROW_W    = 5,
  parameter int                 CELL_W   = 64,
  parameter int                 CELL_H   = 24,
  parameter int                 X_ORG    = 0,
  parameter int                 Y_ORG    = 0,
  parameter int                 X_W      = 10,
  parameter int                 Y_W      = 9,
  parameter int                 COLOR_W  = 9,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(9'h1FF)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     update,
  input  logic                     clear_req,
  input  logic [CELLS*COL_W-1:0]   cur_cols,
  input  logic [CELLS*ROW_W-1:0]   cur_rows,
  input  logic [COLOR_W-1:0]       cur_color,
  cell_redraw_seq_if.master        pnt,
  output logic                     busy,
  output logic                     frame_done,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_LATCH, S_CLEAR} state_t;

  localparam int                 IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [COL_W-1:0]   LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W:0]     COLS_X   = (COL_W+1)'(COLS);
  localparam logic [ROW_W:0]     ROWS_X   = (ROW_W+1)'(ROWS);

  state_t                 state, state_d;
  logic [IDX_W-1:0]       idx;
  logic [COL_W-1:0]       clr_col;
  logic [ROW_W-1:0]       clr_row;
  logic                   kicked, have_prev, pend_upd, pend_clr;
  logic [CELLS*COL_W-1:0] prev_cols, new_cols;
  logic [CELLS*ROW_W-1:0] prev_rows, new_rows;
  logic [COLOR_W-1:0]     new_color;

  logic [COL_W-1:0]       sel_col;
  logic [ROW_W-1:0]       sel_row;
  logic                   overlap, off_grid;
  logic [X_W-1:0]         x0_d;
  logic [Y_W-1:0]         y0_d;
  logic                   kick, adv, last, take_clr, take_upd, frame_done_d;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Cell currently addressed by the walker, and whether it can be skipped.
  always_comb begin
    sel_col = '0;
    sel_row = '0;
    overlap = 1'b0;
    case (state)
      S_ERASE: begin
        sel_col = prev_cols[idx*COL_W +: COL_W];
        sel_row = prev_rows[idx*ROW_W +: ROW_W];
      end
      S_DRAW: begin
        sel_col = new_cols[idx*COL_W +: COL_W];
        sel_row = new_rows[idx*ROW_W +: ROW_W];
      end
      S_CLEAR: begin
        sel_col = clr_col;
        sel_row = clr_row;
      end
      default: ;
    endcase
    for (int j = 0; j < CELLS; j++) begin
      if (sel_col == new_cols[j*COL_W +: COL_W] && sel_row == new_rows[j*ROW_W +: ROW_W])
        overlap = 1'b1;
    end
    off_grid = ({1'b0, sel_col} >= COLS_X) || ({1'b0, sel_row} >= ROWS_X);
    x0_d     = X_W'(X_ORG + int'(sel_col) * CELL_W);
    y0_d     = Y_W'(Y_ORG + int'(sel_row) * CELL_H);
  end

  always_comb begin
    state_d      = state;
    kick         = 1'b0;
    adv          = 1'b0;
    last         = 1'b0;
    take_clr     = 1'b0;
    take_upd     = 1'b0;
    frame_done_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_clr || clear_req) begin
          take_clr = 1'b1;
          state_d  = S_CLEAR;
        end else if (pend_upd || update) begin
          take_upd = 1'b1;
          state_d  = have_prev ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW, S_CLEAR: begin
        last = (state == S_CLEAR) ? (clr_col == LAST_COL && clr_row == LAST_ROW)
                                  : (idx == LAST_IDX);
        if (off_grid || (state == S_ERASE && overlap)) adv = 1'b1;
        else if (!kicked) kick = !pnt.pnt_busy;
        else adv = pnt.pnt_done;
        if (adv && last) begin
          if (state == S_ERASE) state_d = S_DRAW;
          else if (state == S_DRAW) state_d = S_LATCH;
          else begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      S_LATCH: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pnt.pnt_start <= 1'b0;
      pnt.pnt_x0    <= '0;
      pnt.pnt_y0    <= '0;
      pnt.pnt_color <= '0;
      frame_done    <= 1'b0;
      idx           <= '0;
      clr_col       <= '0;
      clr_row       <= '0;
      kicked        <= 1'b0;
      have_prev     <= 1'b0;
      pend_upd      <= 1'b0;
      pend_clr      <= 1'b0;
      prev_cols     <= '0;
      prev_rows     <= '0;
      new_cols      <= '0;
      new_rows      <= '0;
      new_color     <= '0;
    end else begin
      pnt.pnt_start <= kick;
      frame_done    <= frame_done_d;
      if (kick) begin
        kicked        <= 1'b1;
        pnt.pnt_x0    <= x0_d;
        pnt.pnt_y0    <= y0_d;
        pnt.pnt_color <= (state == S_DRAW) ? new_color : BG_COLOR;
      end
      if (adv) begin
        kicked <= 1'b0;
        idx    <= last ? '0 : idx + 1'b1;
        if (state == S_CLEAR) begin
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            clr_row <= clr_row + 1'b1;
          end else begin
            clr_col <= clr_col + 1'b1;
          end
          if (last) have_prev <= 1'b0;
        end
      end
      // Requests arriving mid-frame are remembered one-deep and served from IDLE.
      if (state != S_IDLE) begin
        if (update)    pend_upd <= 1'b1;
        if (clear_req) pend_clr <= 1'b1;
      end
      if (take_clr) begin
        pend_clr <= 1'b0;
        clr_col  <= '0;
        clr_row  <= '0;
        idx      <= '0;
        if (update) pend_upd <= 1'b1;
      end
      if (take_upd) begin
        pend_upd  <= 1'b0;
        new_cols  <= cur_cols;
        new_rows  <= cur_rows;
        new_color <= cur_color;
        idx       <= '0;
      end
      if (state == S_LATCH) begin
        prev_cols <= new_cols;
        prev_rows <= new_rows;
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cell_redraw_seq.sv
// Bench for cell_redraw_seq: behavioural painter, piece-level reference model and kick scoreboard.
module tb_cell_redraw_seq;

  logic        CLOCK_50 = 1'b0;
  logic        reset, update, clear_req;
  logic [15:0] cur_cols;
  logic [19:0] cur_rows;
  logic [8:0]  cur_color;
  logic        busy, frame_done;
  logic [2:0]  state_dbg;
  logic        p_busy, p_done, force_busy;

  cell_redraw_seq_if #(.X_W(10), .Y_W(9), .COLOR_W(9)) pif ();

  assign pif.pnt_busy = p_busy | force_busy;
  assign pif.pnt_done = p_done;

  cell_redraw_seq dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .update     (update),
    .clear_req  (clear_req),
    .cur_cols   (cur_cols),
    .cur_rows   (cur_rows),
    .cur_color  (cur_color),
    .pnt        (pif),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          checks = 0;
  int          errors = 0;
  int          kick_cnt = 0;
  bit          sb_off = 1'b0;
  bit          p_out = 1'b0;
  int          lat = 0;
  logic [27:0] last_kick = '0;
  logic [27:0] cap = '0;
  logic [27:0] exp_q[$];

  int nc[4], nr[4], pc[4], pr[4];
  bit m_have_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the expected paint list of a frame, from the piece-level rules.
  task automatic push_cell(input int col, input int row, input logic [8:0] color);
    exp_q.push_back({10'(col * 64), 9'(row * 24), color});
  endtask

  task automatic model_update(input logic [8:0] color);
    if (m_have_prev) begin
      for (int i = 0; i < 4; i++) begin
        if (pc[i] < 10 && pr[i] < 20) begin
          bit hit = 1'b0;
          for (int j = 0; j < 4; j++) if (nc[j] == pc[i] && nr[j] == pr[i]) hit = 1'b1;
          if (!hit) push_cell(pc[i], pr[i], 9'h1FF);
        end
      end
    end
    for (int i = 0; i < 4; i++) if (nc[i] < 10 && nr[i] < 20) push_cell(nc[i], nr[i], color);
    for (int i = 0; i < 4; i++) begin
      pc[i] = nc[i];
      pr[i] = nr[i];
    end
    m_have_prev = 1'b1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) push_cell(c, r, 9'h1FF);
    m_have_prev = 1'b0;
  endtask

  task automatic set_piece(input int c0, input int r0, input int c1, input int r1,
                           input int c2, input int r2, input int c3, input int r3);
    nc[0] = c0; nr[0] = r0; nc[1] = c1; nr[1] = r1;
    nc[2] = c2; nr[2] = r2; nc[3] = c3; nr[3] = r3;
  endtask

  task automatic rand_piece();
    bit shift = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < 4; i++) begin
      if (shift) begin
        nc[i] = (pc[i] + 1) % 12;
        nr[i] = pr[i];
      end else begin
        nc[i] = $urandom_range(0, 11);
        nr[i] = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 21);
      end
    end
  endtask

  task automatic drive_cur();
    for (int i = 0; i < 4; i++) begin
      cur_cols[i*4 +: 4] = 4'(nc[i]);
      cur_rows[i*5 +: 5] = 5'(nr[i]);
    end
  endtask

  task automatic do_update(input logic [8:0] color, input bit scramble);
    model_update(color);
    @(negedge CLOCK_50);
    drive_cur();
    cur_color = color;
    update = 1'b1;
    @(negedge CLOCK_50);
    update = 1'b0;
    if (scramble) begin
      cur_cols  = 16'($urandom);
      cur_rows  = 20'($urandom);
      cur_color = 9'($urandom);
    end
  endtask

  task automatic pulse_clear();
    @(negedge CLOCK_50);
    clear_req = 1'b1;
    @(negedge CLOCK_50);
    clear_req = 1'b0;
  endtask

  task automatic wait_frame(input int budget, input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_frame_done"}, frame_done, 1);
    check({tag, "_exp_drained"}, exp_q.size(), 0);
    @(negedge CLOCK_50);
  endtask

  // Behavioural painter: random completion latency, scoreboard on every kick.
  initial begin
    p_busy = 1'b0;
    p_done = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      p_done = 1'b0;
      if (p_out) begin
        if (lat == 0) begin
          if (!sb_off) check("hold_stable", {pif.pnt_x0, pif.pnt_y0, pif.pnt_color}, cap);
          p_done = 1'b1;
          p_busy = 1'b0;
          p_out  = 1'b0;
        end else begin
          lat--;
        end
      end
      if (pif.pnt_start === 1'b1) begin
        kick_cnt++;
        last_kick = {pif.pnt_x0, pif.pnt_y0, pif.pnt_color};
        if (!sb_off) begin
          check("single_outstanding", p_out, 0);
          if (exp_q.size() == 0) check("unexpected_kick", exp_q.size(), 1);
          else check("kick", last_kick, exp_q.pop_front());
        end
        cap    = last_kick;
        p_out  = 1'b1;
        p_busy = 1'b1;
        lat    = $urandom_range(1, 5);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, n;
    reset = 1'b1; update = 1'b0; clear_req = 1'b0; force_busy = 1'b0;
    cur_cols = '0; cur_rows = '0; cur_color = '0;
    for (int i = 0; i < 4; i++) begin pc[i] = 0; pr[i] = 31; end
    repeat (3) @(negedge CLOCK_50);
    check("rst_start", pif.pnt_start, 0);
    check("rst_x0", pif.pnt_x0, 0);
    check("rst_y0", pif.pnt_y0, 0);
    check("rst_color", pif.pnt_color, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    check("no_clear_on_reset", busy, 0);
    check("no_kick_on_reset", kick_cnt, 0);

    set_piece(3, 5, 0, 31, 0, 31, 0, 31);
    k0 = kick_cnt;
    do_update(9'h0A5, 1'b1);
    wait_frame(500, "single");
    check("single_kicks", kick_cnt - k0, 1);
    check("single_box", last_kick, {10'd192, 9'd120, 9'h0A5});

    set_piece(4, 5, 0, 31, 0, 31, 0, 31);
    k0 = kick_cnt;
    do_update(9'h0A5, 1'b1);
    wait_frame(500, "move");
    check("move_kicks", kick_cnt - k0, 2);
    check("move_box", last_kick, {10'd256, 9'd120, 9'h0A5});

    set_piece(4, 0, 5, 0, 6, 0, 5, 1);
    do_update(9'h033, 1'b1);
    wait_frame(500, "t_old");
    set_piece(4, 1, 5, 1, 6, 1, 5, 2);
    k0 = kick_cnt;
    do_update(9'h033, 1'b1);
    wait_frame(500, "t_new");
    check("t_kicks", kick_cnt - k0, 7);

    repeat (15) begin
      rand_piece();
      do_update(9'($urandom), 1'b1);
      wait_frame(500, "rand");
    end

    k0 = kick_cnt;
    model_clear();
    pulse_clear();
    wait_frame(4000, "clear");
    check("clear_kicks", kick_cnt - k0, 200);
    check("clear_last_box", last_kick, {10'd576, 9'd456, 9'h1FF});
    set_piece(0, 0, 1, 0, 2, 0, 3, 0);
    k0 = kick_cnt;
    do_update(9'h111, 1'b1);
    wait_frame(500, "post_clear");
    check("post_clear_kicks", kick_cnt - k0, 4);

    set_piece(0, 2, 1, 3, 2, 4, 3, 5);
    do_update(9'h0C3, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    check("coal_busy", busy, 1);
    rand_piece();
    drive_cur();
    cur_color = 9'($urandom);
    update = 1'b1;
    @(negedge CLOCK_50);
    update = 1'b0;
    set_piece(7, 10, 8, 10, 7, 11, 8, 11);
    drive_cur();
    cur_color = 9'h07E;
    update = 1'b1;
    @(negedge CLOCK_50);
    update = 1'b0;
    clear_req = 1'b1;
    @(negedge CLOCK_50);
    clear_req = 1'b0;
    wait_frame(500, "coal_a");
    model_clear();
    wait_frame(4000, "coal_clear");
    model_update(9'h07E);
    wait_frame(500, "coal_c");
    n = 0;
    repeat (100) begin
      @(negedge CLOCK_50);
      if (busy) n++;
    end
    check("coal_no_extra", n, 0);

    force_busy = 1'b1;
    set_piece(2, 3, 7, 31, 1, 19, 9, 0);
    k0 = kick_cnt;
    do_update(9'h155, 1'b1);
    n = 0;
    repeat (50) begin
      @(negedge CLOCK_50);
      if (pif.pnt_start === 1'b1) n++;
    end
    check("hold_no_kick", n, 0);
    check("hold_busy", busy, 1);
    force_busy = 1'b0;
    wait_frame(500, "hold");
    check("hold_kicks", kick_cnt - k0, 7);

    set_piece(0, 0, 1, 0, 0, 1, 1, 1);
    do_update(9'h0F0, 1'b1);
    n = 0;
    while (!(state_dbg == 3'd1 && p_out) && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("reach_erase_kick", (state_dbg == 3'd1 && p_out), 1);
    sb_off = 1'b1;
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid_rst_start", pif.pnt_start, 0);
    check("mid_rst_x0", pif.pnt_x0, 0);
    check("mid_rst_y0", pif.pnt_y0, 0);
    check("mid_rst_color", pif.pnt_color, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_dbg, 0);
    reset = 1'b0;
    exp_q.delete();
    m_have_prev = 1'b0;
    n = 0;
    while (p_out && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (5) @(negedge CLOCK_50);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_frame", frame_done, 0);
    sb_off = 1'b0;

    set_piece(5, 5, 5, 6, 12, 0, 0, 31);
    k0 = kick_cnt;
    do_update(9'h1C7, 1'b1);
    wait_frame(500, "after_rst");
    check("after_rst_kicks", kick_cnt - k0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
